vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock. Provides the pixel coordinates (x, y), the video_on qualifier and the hsync/vsync pins consumed by every text/page display block (rgb generators) and the top-level VGA port. Display blocks register rgb on clk and sample x/y/video_on, so all timing outputs are registered and mutually aligned.

---
 rtl/vga_sync_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator (pixel tick, x/y counters, syncs)
// Optional: define VGA_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_sync_gen #(
   parameter int HD      = 640,
   parameter int HF      = 16,
   parameter int HR      = 96,
   parameter int HB      = 48,
   parameter int VD      = 480,
   parameter int VF      = 10,
   parameter int VR      = 2,
   parameter int VB      = 33,
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_count
`endif
);

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
   localparam logic [9:0]    H_LAST    = 10'(HD + HF + HR + HB - 1);
   localparam logic [9:0]    V_LAST    = 10'(VD + VF + VR + VB - 1);
   localparam logic [9:0]    H_DISP    = 10'(HD);
   localparam logic [9:0]    V_DISP    = 10'(VD);
   localparam logic [9:0]    HS_FIRST  = 10'(HD + HF);
   localparam logic [9:0]    HS_LAST   = 10'(HD + HF + HR - 1);
   localparam logic [9:0]    VS_FIRST  = 10'(VD + VF);
   localparam logic [9:0]    VS_LAST   = 10'(VD + VF + VR - 1);

   logic [TW-1:0] r_tick;
   logic          r_p_tick;
   logic [9:0]    r_x;
   logic [9:0]    r_y;
   logic          r_video_on;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_frame_start;

   logic          w_tick;
   logic          w_h_end;
   logic          w_v_end;
   logic [9:0]    w_x_next;
   logic [9:0]    w_y_next;

   // Next-state counter values; decodes are taken from these so all outputs move together
   always_comb begin
      w_tick   = (r_tick == TICK_LAST);
      w_h_end  = (r_x == H_LAST);
      w_v_end  = (r_y == V_LAST);
      w_x_next = r_x;
      w_y_next = r_y;
      if (w_tick) begin
         w_x_next = w_h_end ? 10'd0 : r_x + 10'd1;
         if (w_h_end) begin
            w_y_next = w_v_end ? 10'd0 : r_y + 10'd1;
         end
      end
   end

   // Pixel divider, position counters and registered sync/blank decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tick        <= '0;
         r_p_tick      <= 1'b0;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_video_on    <= 1'b1;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_tick        <= w_tick ? '0 : r_tick + TW'(1);
         r_p_tick      <= w_tick;
         r_x           <= w_x_next;
         r_y           <= w_y_next;
         r_video_on    <= (w_x_next < H_DISP) && (w_y_next < V_DISP);
         r_hsync       <= !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
         r_vsync       <= !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
         r_frame_start <= w_tick && w_h_end && w_v_end;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] r_frame_count;

   // Frame counter for blink timing; wraps naturally at 8 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_count <= 8'd0;
      end else if (w_tick && w_h_end && w_v_end) begin
         r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign frame_count = r_frame_count;
`endif

   assign p_tick      = r_p_tick;
   assign x           = r_x;
   assign y           = r_y;
   assign video_on    = r_video_on;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen against a pixel-count model
`timescale 1ns/1ps
module tb_vga_sync_gen;

   // Small geometry instance so whole frames fit in a short run
   localparam int S_HD = 4, S_HF = 1, S_HR = 2, S_HB = 1;
   localparam int S_VD = 3, S_VF = 1, S_VR = 1, S_VB = 1;
   localparam int S_D  = 2;
   localparam int S_FRAME_CLKS = (S_HD+S_HF+S_HR+S_HB) * (S_VD+S_VF+S_VR+S_VB) * S_D;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_frame_start;
   logic [9:0] b_x, b_y;
   logic       s_p_tick, s_video_on, s_hsync, s_vsync, s_frame_start;
   logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] b_frame_count, s_frame_count;
`endif

   int checks = 0;
   int errors = 0;
   int k;   // rising edges since reset release

   always #5 clk = ~clk;

   vga_sync_gen u_big (
      .clk(clk), .reset(reset), .p_tick(b_p_tick), .x(b_x), .y(b_y),
      .video_on(b_video_on), .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_frame_start)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(b_frame_count)
`endif
   );

   vga_sync_gen #(
      .HD(S_HD), .HF(S_HF), .HR(S_HR), .HB(S_HB),
      .VD(S_VD), .VF(S_VF), .VR(S_VR), .VB(S_VB), .CLK_DIV(S_D)
   ) u_small (
      .clk(clk), .reset(reset), .p_tick(s_p_tick), .x(s_x), .y(s_y),
      .video_on(s_video_on), .hsync(s_hsync), .vsync(s_vsync), .frame_start(s_frame_start)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(s_frame_count)
`endif
   );

   always @(posedge clk or posedge reset) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   // Expected outputs after k edges: pixel number is k/D, position follows by division
   function automatic logic [31:0] model(input int kk, input int hd, input int hf, input int hr,
                                         input int hb, input int vd, input int vf, input int vr,
                                         input int vb, input int d, output int fc);
      int hmax, vmax, p, mx, my;
      logic pt, fs, hs, vs, vo;
      hmax = hd + hf + hr + hb;
      vmax = vd + vf + vr + vb;
      p  = kk / d;
      mx = p % hmax;
      my = (p / hmax) % vmax;
      pt = (kk > 0) && (kk % d == 0);
      fs = pt && (p % (hmax * vmax) == 0);
      hs = !(mx >= hd + hf && mx < hd + hf + hr);
      vs = !(my >= vd + vf && my < vd + vf + vr);
      vo = (mx < hd) && (my < vd);
      fc = (p / (hmax * vmax)) % 256;
      return {7'd0, pt, mx[9:0], my[9:0], vo, hs, vs, fs};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      int fc;
      logic [31:0] e;
      e = model(k, 640, 16, 96, 48, 480, 10, 2, 33, 4, fc);
      chk("big", {7'd0, b_p_tick, b_x, b_y, b_video_on, b_hsync, b_vsync, b_frame_start}, e);
`ifdef VGA_FRAME_CNT_EN
      chk("big_fc", {24'd0, b_frame_count}, 32'(fc));
`endif
      e = model(k, S_HD, S_HF, S_HR, S_HB, S_VD, S_VF, S_VR, S_VB, S_D, fc);
      chk("small", {7'd0, s_p_tick, s_x, s_y, s_video_on, s_hsync, s_vsync, s_frame_start}, e);
`ifdef VGA_FRAME_CNT_EN
      chk("small_fc", {24'd0, s_frame_count}, 32'(fc));
`endif
   end

   task automatic wait_k(input int target);
      while (k < target) @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(3);

      // First line on the default geometry, hand-computed points
      wait_k(3);   chk("ptick_k3", 32'(b_p_tick), 32'd0);
      wait_k(4);   chk("ptick_k4", 32'(b_p_tick), 32'd1);
      wait_k(40);  chk("x_40clk", 32'(b_x), 32'd10);
                   chk("vo_40clk", 32'(b_video_on), 32'd1);
      wait_k(2559); chk("vo_x639", 32'(b_video_on), 32'd1);
      wait_k(2560); chk("vo_x640", 32'(b_video_on), 32'd0);
      wait_k(2623); chk("hs_x655", 32'(b_hsync), 32'd1);
      wait_k(2624); chk("hs_x656", 32'(b_hsync), 32'd0);
      wait_k(3007); chk("hs_x751", 32'(b_hsync), 32'd0);
      wait_k(3008); chk("hs_x752", 32'(b_hsync), 32'd1);
      wait_k(3200); chk("wrap_xy", {22'd0, b_x}, 32'd0);
                    chk("wrap_y1", {22'd0, b_y}, 32'd1);

      // Async reset on the small instance while both syncs are low (x=5, y=4)
      do_reset(2);
      wait_k(74);
      chk("pre_rst_hs", 32'(s_hsync), 32'd0);
      chk("pre_rst_vs", 32'(s_vsync), 32'd0);
      @(posedge clk);
      #1.3 reset = 1'b1;
      #0.2;
      chk("arst_small", {s_p_tick, s_x, s_y, s_video_on, s_hsync, s_vsync, s_frame_start},
          {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
      chk("arst_big", {b_p_tick, b_x, b_y, b_video_on, b_hsync, b_vsync, b_frame_start},
          {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      wait_k(S_FRAME_CLKS - 1);
      chk("pre_wrap_vo", 32'(s_video_on), 32'd0);
      wait_k(S_FRAME_CLKS);
      chk("frame_start", 32'(s_frame_start), 32'd1);
      chk("wrap_vo_hs", {30'd0, s_video_on, s_hsync}, 32'd3);

      // Randomized reset assertions at arbitrary points inside the clock period
      for (int i = 0; i < 20; i++) begin
         int run;
         run = $urandom_range(1, 1500);
         repeat (run) @(negedge clk);
         @(posedge clk);
         #($urandom_range(1, 9) * 1.0) reset = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         reset = 1'b0;
      end

      // Frame counting over 257 small frames
      do_reset(2);
`ifdef VGA_FRAME_CNT_EN
      wait_k(S_FRAME_CLKS);       chk("fc_1", 32'(s_frame_count), 32'd1);
      wait_k(S_FRAME_CLKS * 255); chk("fc_255", 32'(s_frame_count), 32'd255);
      wait_k(S_FRAME_CLKS * 256); chk("fc_256", 32'(s_frame_count), 32'd0);
      wait_k(S_FRAME_CLKS * 257); chk("fc_257", 32'(s_frame_count), 32'd1);
`else
      wait_k(S_FRAME_CLKS * 4);
      chk("f4_start", 32'(s_frame_start), 32'd1);
`endif
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
